// File: rtl/dbus_pkg.sv
// Shared types for the data-bus arbiter: owner states, request payload, defaults.
package dbus_pkg;

  localparam int unsigned DBUS_DEFAULT_MAX_WAIT = 4;
  localparam int unsigned DBUS_ADDR_W           = 32;
  localparam int unsigned DBUS_DATA_W           = 32;

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_CPU,
    OWN_DMA_LOCKED
  } dbus_owner_e;

  typedef struct packed {
    logic                   we;
    logic [DBUS_ADDR_W-1:0] addr;
    logic [DBUS_DATA_W-1:0] wdata;
  } dbus_req_t;

endpackage

// File: rtl/dbus_arbiter_if.sv
// CPU, DMA and memory-side signals of the data-bus arbiter.
// slave = arbiter view, master = environment view.
interface dbus_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);

  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_gnt;
  logic                  cpu_stall;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_rvalid;

  logic                  dma_req;
  logic                  dma_we;
  logic                  dma_lock;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata;
  logic                  dma_gnt;
  logic [DATA_WIDTH-1:0] dma_rdata;
  logic                  dma_rvalid;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rdata, cpu_rvalid,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dbus_rsp_reg.sv
// Per-requester read-return register: captures memory data at the end of a
// granted read and flags it valid for exactly the following cycle.
module dbus_rsp_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_capture,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid
);

  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= i_capture;
      if (i_capture) begin
        r_rdata <= i_rdata;
      end
    end
  end

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;

endmodule

// File: rtl/dbus_arbiter.sv
// Data-memory port arbiter: CPU fixed priority, DMA lockable bursts.
// Define DBUS_ARB_STARVE_EN to force DMA through after MAX_WAIT lost cycles.
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = DBUS_DEFAULT_MAX_WAIT
) (
  input logic           clk,
  input logic           reset,
  dbus_arbiter_if.slave bus
);

  if (MAX_WAIT < 1 || ADDR_WIDTH > DBUS_ADDR_W || DATA_WIDTH > DBUS_DATA_W) begin : g_param_chk
    $error("dbus_arbiter: illegal parameter value");
  end

  dbus_owner_e r_owner;
  dbus_owner_e w_owner_nxt;
  logic        w_cpu_gnt;
  logic        w_dma_gnt;
  logic        w_force;
  dbus_req_t   w_cpu_rq;
  dbus_req_t   w_dma_rq;
  dbus_req_t   w_sel;

  assign w_cpu_rq = '{we:    bus.cpu_we,
                      addr:  DBUS_ADDR_W'(bus.cpu_addr),
                      wdata: DBUS_DATA_W'(bus.cpu_wdata)};
  assign w_dma_rq = '{we:    bus.dma_we,
                      addr:  DBUS_ADDR_W'(bus.dma_addr),
                      wdata: DBUS_DATA_W'(bus.dma_wdata)};

`ifdef DBUS_ARB_STARVE_EN
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;

  assign w_force = bus.dma_req && (r_wait_cnt == WAIT_W'(MAX_WAIT));

  // Consecutive cycles DMA has asked and lost; saturates at MAX_WAIT.
  always_comb begin
    w_wait_nxt = '0;
    if (bus.dma_req && !w_dma_gnt) begin
      w_wait_nxt = (r_wait_cnt == WAIT_W'(MAX_WAIT)) ? r_wait_cnt
                                                     : r_wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= w_wait_nxt;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner <= OWN_IDLE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  // Grants are same-cycle; reset masks them so nothing leaks while held.
  always_comb begin
    w_owner_nxt = r_owner;
    w_cpu_gnt   = 1'b0;
    w_dma_gnt   = 1'b0;
    if (!reset) begin
      if (r_owner == OWN_DMA_LOCKED) begin
        w_dma_gnt = bus.dma_req;
      end else if (bus.cpu_req && !w_force) begin
        w_cpu_gnt = 1'b1;
      end else begin
        w_dma_gnt = bus.dma_req;
      end
    end
    case (r_owner)
      OWN_DMA_LOCKED: begin
        if (!bus.dma_lock) begin
          w_owner_nxt = OWN_IDLE;
        end
      end
      default: begin
        if (w_dma_gnt) begin
          w_owner_nxt = bus.dma_lock ? OWN_DMA_LOCKED : OWN_IDLE;
        end else if (w_cpu_gnt) begin
          w_owner_nxt = OWN_CPU;
        end else begin
          w_owner_nxt = OWN_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    w_sel = '0;
    if (w_cpu_gnt) begin
      w_sel = w_cpu_rq;
    end else if (w_dma_gnt) begin
      w_sel = w_dma_rq;
    end
  end

  assign bus.cpu_gnt   = w_cpu_gnt;
  assign bus.dma_gnt   = w_dma_gnt;
  assign bus.cpu_stall = bus.cpu_req & ~w_cpu_gnt & ~reset;
  assign bus.mem_en    = w_cpu_gnt | w_dma_gnt;
  assign bus.mem_we    = w_sel.we;
  assign bus.mem_addr  = ADDR_WIDTH'(w_sel.addr);
  assign bus.mem_wdata = DATA_WIDTH'(w_sel.wdata);

  dbus_rsp_reg #(.DATA_WIDTH(DATA_WIDTH)) u_cpu_rsp (
    .clk       (clk),
    .reset     (reset),
    .i_capture (w_cpu_gnt & ~bus.cpu_we),
    .i_rdata   (bus.mem_rdata),
    .o_rdata   (bus.cpu_rdata),
    .o_rvalid  (bus.cpu_rvalid)
  );

  dbus_rsp_reg #(.DATA_WIDTH(DATA_WIDTH)) u_dma_rsp (
    .clk       (clk),
    .reset     (reset),
    .i_capture (w_dma_gnt & ~bus.dma_we),
    .i_rdata   (bus.mem_rdata),
    .o_rdata   (bus.dma_rdata),
    .o_rvalid  (bus.dma_rvalid)
  );

endmodule

// File: tb/tb_dbus_arbiter.sv
// Randomised and directed bench for dbus_arbiter against a cycle-level reference model.
module tb_dbus_arbiter;

  localparam int MAXW = 4;

  logic clk;
  logic reset;

  dbus_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  dbus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_WAIT(MAXW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  // Environment memory: combinational read, written on granted writes.
  logic [31:0] env_mem [256];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= init_val(i);
    end else if (bus.mem_en && bus.mem_we) begin
      env_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = env_mem[bus.mem_addr[9:2]];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [256];
  bit          m_locked;
  int          m_losses;
  bit          m_cpu_rvalid, m_dma_rvalid;
  logic [31:0] m_cpu_rdata, m_dma_rdata;
  bit          last_cpu_gnt, last_dma_gnt;
  int          obs_dma;

  task automatic model_reset();
    m_locked     = 1'b0;
    m_losses     = 0;
    m_cpu_rvalid = 1'b0;
    m_dma_rvalid = 1'b0;
    m_cpu_rdata  = '0;
    m_dma_rdata  = '0;
    last_cpu_gnt = 1'b0;
    last_dma_gnt = 1'b0;
  endtask

  // One clock: check at negedge from current inputs, advance model at posedge.
  task automatic run_cycle();
    bit          e_cpu, e_dma, e_we, starve;
    logic [31:0] e_addr, e_wdata;
    @(negedge clk);
    starve = 1'b0;
`ifdef DBUS_ARB_STARVE_EN
    starve = bus.dma_req && (m_losses >= MAXW);
`endif
    if (m_locked) begin
      e_cpu = 1'b0;
      e_dma = bus.dma_req;
    end else begin
      e_cpu = bus.cpu_req && !starve;
      e_dma = bus.dma_req && !e_cpu;
    end
    e_we = 1'b0; e_addr = '0; e_wdata = '0;
    if (e_cpu) begin
      e_we = bus.cpu_we; e_addr = bus.cpu_addr; e_wdata = bus.cpu_wdata;
    end else if (e_dma) begin
      e_we = bus.dma_we; e_addr = bus.dma_addr; e_wdata = bus.dma_wdata;
    end
    chk("cpu_gnt",    bus.cpu_gnt,    e_cpu);
    chk("dma_gnt",    bus.dma_gnt,    e_dma);
    chk("cpu_stall",  bus.cpu_stall,  bus.cpu_req && !e_cpu);
    chk("mem_en",     bus.mem_en,     e_cpu || e_dma);
    chk("mem_we",     bus.mem_we,     e_we);
    chk("mem_addr",   bus.mem_addr,   e_addr);
    chk("mem_wdata",  bus.mem_wdata,  e_wdata);
    chk("cpu_rvalid", bus.cpu_rvalid, m_cpu_rvalid);
    chk("cpu_rdata",  bus.cpu_rdata,  m_cpu_rdata);
    chk("dma_rvalid", bus.dma_rvalid, m_dma_rvalid);
    chk("dma_rdata",  bus.dma_rdata,  m_dma_rdata);
    if (bus.dma_gnt === 1'b1) obs_dma++;
    @(posedge clk);
    m_cpu_rvalid = e_cpu && !bus.cpu_we;
    m_dma_rvalid = e_dma && !bus.dma_we;
    if (m_cpu_rvalid) m_cpu_rdata = ref_mem[widx(bus.cpu_addr)];
    if (m_dma_rvalid) m_dma_rdata = ref_mem[widx(bus.dma_addr)];
    if ((e_cpu || e_dma) && e_we) ref_mem[widx(e_addr)] = e_wdata;
    m_locked     = bus.dma_lock && (m_locked || e_dma);
    m_losses     = (bus.dma_req && !e_dma) ? m_losses + 1 : 0;
    last_cpu_gnt = e_cpu;
    last_dma_gnt = e_dma;
    #1;
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wd);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
  endtask

  task automatic set_dma(input bit req, input bit we, input bit lock, input logic [31:0] addr,
                         input logic [31:0] wd);
    bus.dma_req = req; bus.dma_we = we; bus.dma_lock = lock; bus.dma_addr = addr; bus.dma_wdata = wd;
  endtask

  initial begin
    int exp_dma;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    model_reset();
    reset = 1'b1;
    set_cpu(1'b1, 1'b0, 32'h100, 32'h0);
    set_dma(1'b1, 1'b0, 1'b0, 32'h104, 32'h0);

    // Held reset with both requesters active
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_gnt",    bus.cpu_gnt,    1'b0);
    chk("rst_dma_gnt",    bus.dma_gnt,    1'b0);
    chk("rst_cpu_stall",  bus.cpu_stall,  1'b0);
    chk("rst_mem_en",     bus.mem_en,     1'b0);
    chk("rst_mem_addr",   bus.mem_addr,   32'h0);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    chk("rst_dma_rvalid", bus.dma_rvalid, 1'b0);
    chk("rst_cpu_rdata",  bus.cpu_rdata,  32'h0);
    chk("rst_dma_rdata",  bus.dma_rdata,  32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Continuous contention from both sides, first CPU read right after reset
    obs_dma = 0;
    run_cycle();
    chk("first_cpu_rvalid", bus.cpu_rvalid, 1'b1);
    chk("first_cpu_rdata",  bus.cpu_rdata,  init_val(32'h40));
    repeat (99) run_cycle();
`ifdef DBUS_ARB_STARVE_EN
    exp_dma = 100 / (MAXW + 1);
`else
    exp_dma = 0;
`endif
    chk("cont_dma_count", 64'(obs_dma), 64'(exp_dma));

    // Quiet cycle, then locked 3-word DMA burst with the CPU waiting
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    run_cycle();
    set_dma(1'b1, 1'b1, 1'b1, 32'h200, 32'h1111_0000);
    run_cycle();
    set_cpu(1'b1, 1'b0, 32'h300, 32'h0);
    set_dma(1'b1, 1'b1, 1'b1, 32'h204, 32'h2222_0000);
    run_cycle();
    set_dma(1'b1, 1'b1, 1'b1, 32'h208, 32'h3333_0000);
    run_cycle();
    set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    run_cycle();
    chk("burst_cpu_waited", bus.cpu_rvalid, 1'b0);
    run_cycle();
    chk("lock_release_cpu_rvalid", bus.cpu_rvalid, 1'b1);

    // CPU write then DMA read of the same word
    set_cpu(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    run_cycle();
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    run_cycle();
    chk("dbeef_rdata",      bus.dma_rdata,  32'hDEAD_BEEF);
    chk("dbeef_dma_rvalid", bus.dma_rvalid, 1'b1);
    chk("dbeef_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    run_cycle();

    // Reset pulse while locked with a read response pending
    set_dma(1'b1, 1'b0, 1'b1, 32'h80, 32'h0);
    run_cycle();
    #1;
    reset = 1'b1;
    #1;
    chk("rstpulse_dma_rvalid", bus.dma_rvalid, 1'b0);
    chk("rstpulse_dma_gnt",    bus.dma_gnt,    1'b0);
    model_reset();
    #1;
    reset = 1'b0;
    set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_cpu(1'b1, 1'b0, 32'h84, 32'h0);
    run_cycle();
    chk("rstpulse_cpu_rdata", bus.cpu_rdata, ref_mem[widx(32'h84)]);

    // Random traffic honouring the hold-while-waiting rules
    for (int n = 0; n < 600; n++) begin
      if (!(bus.cpu_req && !last_cpu_gnt)) begin
        set_cpu(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                {22'd0, 8'($urandom), 2'b00}, $urandom);
      end
      if (!(bus.dma_req && !last_dma_gnt)) begin
        set_dma(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), {22'd0, 8'($urandom), 2'b00}, $urandom);
      end
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
